mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares the single main-memory port between the instruction cache (requester 0) and the data cache (requester 1). Both caches use the 128-bit line-fill/write-back handshake on their cache-to-memory side. It sits between the two caches' memory ports and the memory model or controller. It uses round-robin arbitration with the grant locked for a full transaction, plus a watchdog that frees the port if memory never answers.

Parameters:
ADDR_W, 32, address width
LINE_W, 128, cache line width in bits
TIMEOUT, 1024, max BUSY cycles before watchdog abort; 0 disables watchdog
TO_CNT_W, 16, watchdog counter width; must hold TIMEOUT

Ports:
clk  in  1  system clock
r  in  1  synchronous active-high reset
icache2arb_valid  in  1  requester 0 request; held until arb2icache_ready
icache2arb_rw  in  1  1=write line, 0=read line
icache2arb_addr  in  ADDR_W  line address
icache2arb_data  in  LINE_W  write line data
arb2icache_data  out  LINE_W  read line data, valid with ready
arb2icache_ready  out  1  one-cycle completion pulse
dcache2arb_valid / _rw / _addr / _data  in  1/1/ADDR_W/LINE_W  requester 1, same meaning
arb2dcache_data  out  LINE_W  as above for requester 1
arb2dcache_ready  out  1  as above for requester 1
arb2mem_valid  out  1  memory request, held until mem2arb_ready
arb2mem_rw  out  1  latched rw of owner
arb2mem_addr  out  ADDR_W  latched addr of owner
arb2mem_data  out  LINE_W  latched write data of owner
mem2arb_data  in  LINE_W  memory read data, valid with mem2arb_ready
mem2arb_ready  in  1  memory completion
arb_busy  out  1  high in BUSY and RESP
arb_owner  out  1  current/last grant: 0=icache, 1=dcache
arb_timeout_err  out  1  sticky; set on watchdog abort

Behaviour:
- Reset (r high at posedge): state=IDLE, all outputs 0, last_grant=1 (icache wins first tie), watchdog counter=0. Reset mid-transaction aborts silently; no ready is issued.
- States: IDLE, BUSY, RESP. All outputs are registered.
- IDLE:
  - If neither valid is high, stay.
  - If exactly one valid is high, grant it.
  - If both are high, grant the requester != last_grant.
  - On grant: latch the winner's rw/addr/data into the arb2mem_* registers, set arb_owner and last_grant to the winner, set arb2mem_valid=1, clear the counter, go to BUSY.
  - A request is first seen on the arb2mem port in the cycle after IDLE samples it.
- BUSY:
  - arb2mem_* are stable. A requester dropping valid mid-transaction is ignored; the transaction completes.
  - If mem2arb_ready: capture mem2arb_data into the response register, drive arb2mem_valid=0, go to RESP.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: response register=0, arb_timeout_err=1, arb2mem_valid=0, go to RESP.
  - Else increment the counter.
- RESP (exactly 1 cycle):
  - The owner's ready=1; the other ready stays 0.
  - Both arb2*_data outputs carry the response register. Consumers sample data only with ready.
  - For a write transaction the response data is don't-care but is still captured.
  - Then go to IDLE.
- Latency: valid seen in IDLE at cycle 0 → arb2mem_valid from cycle 1 → memory ready in cycle k≥1 → owner ready in cycle k+1. Minimum is 2 cycles.
- The requester deasserts valid on the edge after ready, so the IDLE cycle following RESP never re-grants a completed request.
- Fairness: while both requesters are continuously valid, grants strictly alternate.
- A requester asserting valid during BUSY/RESP waits, with no loss; it is arbitrated in the next IDLE cycle.
- mem2arb_ready outside BUSY is ignored.
- arb_timeout_err clears only on reset.

Decomposition:
- Shared package mem_arb_pkg holds the state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2) and the requester IDs (REQ_ICACHE=0, REQ_DCACHE=1). The existing cache already uses ADDR_W and LINE_W, so those localparams go in this package too.
- One natural sub-module: rr_arb2, a combinational 2-way round-robin picker (req[1:0], last_grant → gnt_valid, gnt_id). The FSM, latches and watchdog stay in mem_arbiter.

Test Plan:
- Reset hold: r=1 for 2 cycles with both valids high → all outputs 0; after release, icache granted first (arb_owner=0).
- Single icache read, addr=0x0000_0040, mem ready 3 cycles after arb2mem_valid with data=128'hDEAD_BEEF... → arb2icache_ready pulses once, data matches, arb2dcache_ready stays 0.
- Both valid continuously, 4 transactions with mem ready after 1 cycle → owner order 0,1,0,1; no overlap of arb2mem_valid between transactions; ready-to-ready spacing of 3 cycles.
- dcache write, addr=0x0000_1000, data=128'h1111_2222_3333_4444_5555_6666_7777_8888 → arb2mem_rw=1 and addr/data stable throughout BUSY even if dcache data changes mid-BUSY.
- TIMEOUT=8, memory never ready → exactly 8 BUSY cycles, then owner ready with data 0, arb_timeout_err=1 and sticky; next request still serviced normally.
- Reset asserted in BUSY cycle 2 → next cycle IDLE, arb2mem_valid=0, no ready pulse, last_grant=1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-cache main-memory arbiter: FSM encoding,
// requester identifiers and the default line/address widths.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// whichever requester was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    unique case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the icache and the dcache; the grant is
// held for a whole line transaction and a watchdog frees a silent memory.
module mem_arbiter
  import mem_arb_pkg::state_t, mem_arb_pkg::IDLE, mem_arb_pkg::BUSY, mem_arb_pkg::RESP,
         mem_arb_pkg::REQ_ICACHE, mem_arb_pkg::REQ_DCACHE;
#(
  parameter int ADDR_W   = mem_arb_pkg::ADDR_W,
  parameter int LINE_W   = mem_arb_pkg::LINE_W,
  parameter int TIMEOUT  = 1024,
  parameter int TO_CNT_W = 16
) (
  input  logic              clk,
  input  logic              r,

  input  logic              icache2arb_valid,
  input  logic              icache2arb_rw,
  input  logic [ADDR_W-1:0] icache2arb_addr,
  input  logic [LINE_W-1:0] icache2arb_data,
  output logic [LINE_W-1:0] arb2icache_data,
  output logic              arb2icache_ready,

  input  logic              dcache2arb_valid,
  input  logic              dcache2arb_rw,
  input  logic [ADDR_W-1:0] dcache2arb_addr,
  input  logic [LINE_W-1:0] dcache2arb_data,
  output logic [LINE_W-1:0] arb2dcache_data,
  output logic              arb2dcache_ready,

  output logic              arb2mem_valid,
  output logic              arb2mem_rw,
  output logic [ADDR_W-1:0] arb2mem_addr,
  output logic [LINE_W-1:0] arb2mem_data,
  input  logic [LINE_W-1:0] mem2arb_data,
  input  logic              mem2arb_ready,

  output logic              arb_busy,
  output logic              arb_owner,
  output logic              arb_timeout_err
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

  state_t              state, state_next;
  logic                last_grant, last_grant_d;
  logic [TO_CNT_W-1:0] to_cnt, to_cnt_d;
  logic [LINE_W-1:0]   resp_data, resp_data_d;

  logic                owner_d, busy_d, err_d;
  logic                mem_valid_d, mem_rw_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [LINE_W-1:0]   mem_data_d;
  logic                icache_ready_d, dcache_ready_d;

  logic                gnt_valid, gnt_id;
  logic                to_expire;

  rr_arb2 u_rr (
    .req        ({dcache2arb_valid, icache2arb_valid}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  assign to_expire = (TIMEOUT != 0) && (to_cnt == TO_LAST);

  // Every output comes straight from a flop; the two comb blocks below only
  // compute the values loaded at the next edge.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // a blocking = here would let later lines see already-updated state.
  always_ff @(posedge clk) begin
    if (r) begin
      state            <= IDLE;
      last_grant       <= REQ_DCACHE;
      to_cnt           <= '0;
      // NOTE: the wide line registers are reset too, because the outputs
      // they drive must read as zero while the arbiter is held in reset.
      resp_data        <= '0;
      arb2mem_valid    <= 1'b0;
      arb2mem_rw       <= 1'b0;
      arb2mem_addr     <= '0;
      arb2mem_data     <= '0;
      arb2icache_ready <= 1'b0;
      arb2dcache_ready <= 1'b0;
      arb_busy         <= 1'b0;
      arb_owner        <= 1'b0;
      arb_timeout_err  <= 1'b0;
    end else begin
      state            <= state_next;
      last_grant       <= last_grant_d;
      to_cnt           <= to_cnt_d;
      resp_data        <= resp_data_d;
      arb2mem_valid    <= mem_valid_d;
      arb2mem_rw       <= mem_rw_d;
      arb2mem_addr     <= mem_addr_d;
      arb2mem_data     <= mem_data_d;
      arb2icache_ready <= icache_ready_d;
      arb2dcache_ready <= dcache_ready_d;
      arb_busy         <= busy_d;
      arb_owner        <= owner_d;
      arb_timeout_err  <= err_d;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (gnt_valid) state_next = BUSY;
      BUSY:    if (mem2arb_ready || to_expire) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every signal gets its hold/idle value before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    last_grant_d   = last_grant;
    to_cnt_d       = to_cnt;
    resp_data_d    = resp_data;
    owner_d        = arb_owner;
    err_d          = arb_timeout_err;
    mem_valid_d    = arb2mem_valid;
    mem_rw_d       = arb2mem_rw;
    mem_addr_d     = arb2mem_addr;
    mem_data_d     = arb2mem_data;
    icache_ready_d = 1'b0;
    dcache_ready_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (gnt_valid) begin
          owner_d      = gnt_id;
          last_grant_d = gnt_id;
          mem_valid_d  = 1'b1;
          mem_rw_d     = gnt_id ? dcache2arb_rw   : icache2arb_rw;
          mem_addr_d   = gnt_id ? dcache2arb_addr : icache2arb_addr;
          mem_data_d   = gnt_id ? dcache2arb_data : icache2arb_data;
          to_cnt_d     = '0;
        end
      end
      BUSY: begin
        // Memory completion wins over a watchdog expiry in the same cycle.
        if (mem2arb_ready || to_expire) begin
          resp_data_d    = mem2arb_ready ? mem2arb_data : '0;
          err_d          = arb_timeout_err | ~mem2arb_ready;
          mem_valid_d    = 1'b0;
          icache_ready_d = (arb_owner == REQ_ICACHE);
          dcache_ready_d = (arb_owner == REQ_DCACHE);
        end else begin
          to_cnt_d = to_cnt + TO_CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign busy_d = (state_next != IDLE);

  // Both caches see the same response bus; only the owner's ready qualifies it.
  assign arb2icache_data = resp_data;
  assign arb2dcache_data = resp_data;

endmodule
